// File: rtl/apb_interconnect_n_pkg.sv
// ---------------------------------------------------------------------------
// apb_interconnect_n_pkg
// Shared types and default address map for the APB interconnect.
//   apb_ic_state_e : interconnect FSM states (IDLE, ACCESS, ABORT)
//   *_BASE/*_LIMIT : default inclusive windows for ROM, Flash, SRAM, CTRL, DIAG
//   DEF_SLV_*      : the same windows packed slave 0 in the low word
// ---------------------------------------------------------------------------
package apb_interconnect_n_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ABORT  = 2'd2
    } apb_ic_state_e;

    localparam logic [31:0] ROM_BASE    = 32'h0000_0000;
    localparam logic [31:0] ROM_LIMIT   = 32'h0000_7FFF;
    localparam logic [31:0] FLASH_BASE  = 32'h0000_8000;
    localparam logic [31:0] FLASH_LIMIT = 32'h0002_7FFF;
    localparam logic [31:0] SRAM_BASE   = 32'h0002_8000;
    localparam logic [31:0] SRAM_LIMIT  = 32'h0002_9FFF;
    localparam logic [31:0] CTRL_BASE   = 32'h0002_A000;
    localparam logic [31:0] CTRL_LIMIT  = 32'h0002_AFFF;
    localparam logic [31:0] DIAG_BASE   = 32'h0002_B000;
    localparam logic [31:0] DIAG_LIMIT  = 32'h0002_BFFF;

    localparam int DEF_NUM_SLAVES = 5;

    localparam logic [5*32-1:0] DEF_SLV_BASE =
        {DIAG_BASE, CTRL_BASE, SRAM_BASE, FLASH_BASE, ROM_BASE};
    localparam logic [5*32-1:0] DEF_SLV_LIMIT =
        {DIAG_LIMIT, CTRL_LIMIT, SRAM_LIMIT, FLASH_LIMIT, ROM_LIMIT};

endpackage

// File: rtl/apb_interconnect_n_if.sv
// ---------------------------------------------------------------------------
// apb_interconnect_n_if
// Bundles the CPU-side and peripheral-side APB signals of the interconnect.
//   m_*   : CPU master request (paddr, psel, penable, pwrite, pwdata, pstrb)
//           and its response (pready, prdata, pslverr)
//   s_*   : broadcast request, one-hot psel, per-slave penable and the packed
//           per-slave responses (slave i at [i*DATA_W +: DATA_W])
// Modports:
//   slave  : the interconnect (completer towards the CPU, requester to slaves)
//   master : the environment around it (CPU plus peripherals)
// ---------------------------------------------------------------------------
interface apb_interconnect_n_if #(
    parameter int NUM_SLAVES = 5,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) ();

    logic [ADDR_W-1:0]            m_paddr;
    logic                         m_psel;
    logic                         m_penable;
    logic                         m_pwrite;
    logic [DATA_W-1:0]            m_pwdata;
    logic [DATA_W/8-1:0]          m_pstrb;
    logic                         m_pready;
    logic [DATA_W-1:0]            m_prdata;
    logic                         m_pslverr;

    logic [ADDR_W-1:0]            s_paddr;
    logic                         s_pwrite;
    logic [DATA_W-1:0]            s_pwdata;
    logic [DATA_W/8-1:0]          s_pstrb;
    logic [NUM_SLAVES-1:0]        s_psel;
    logic [NUM_SLAVES-1:0]        s_penable;
    logic [NUM_SLAVES-1:0]        s_pready;
    logic [NUM_SLAVES*DATA_W-1:0] s_prdata;
    logic [NUM_SLAVES-1:0]        s_pslverr;

    modport slave (
        input  m_paddr, m_psel, m_penable, m_pwrite, m_pwdata, m_pstrb,
        input  s_pready, s_prdata, s_pslverr,
        output m_pready, m_prdata, m_pslverr,
        output s_paddr, s_pwrite, s_pwdata, s_pstrb, s_psel, s_penable
    );

    modport master (
        output m_paddr, m_psel, m_penable, m_pwrite, m_pwdata, m_pstrb,
        output s_pready, s_prdata, s_pslverr,
        input  m_pready, m_prdata, m_pslverr,
        input  s_paddr, s_pwrite, s_pwdata, s_pstrb, s_psel, s_penable
    );

endinterface

// File: rtl/apb_interconnect_n_addr_decoder.sv
// ---------------------------------------------------------------------------
// apb_addr_decoder
// Base/limit address decode for NUM_SLAVES windows.
//   paddr    in  : master address
//   psel     in  : master select (qualifies unmapped)
//   dec      out : one-hot (or zero) hit vector, lowest index wins on overlap
//   unmapped out : psel asserted with no window hit
// ---------------------------------------------------------------------------
module apb_addr_decoder #(
    parameter int                           NUM_SLAVES = 5,
    parameter int                           ADDR_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE   = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_LIMIT  = '0
) (
    input  logic [ADDR_W-1:0]     paddr,
    input  logic                  psel,
    output logic [NUM_SLAVES-1:0] dec,
    output logic                  unmapped
);

    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] limit;

    // Scan from the top index down and restart the vector on every hit, so
    // the last hit standing is the lowest index and dec stays one-hot.
    always_comb begin
        dec   = '0;
        base  = '0;
        limit = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            base  = SLV_BASE[i*ADDR_W +: ADDR_W];
            limit = SLV_LIMIT[i*ADDR_W +: ADDR_W];
            if ((paddr >= base) && (paddr <= limit)) begin
                dec    = '0;
                dec[i] = 1'b1;
            end
        end
    end

    assign unmapped = psel & ~(|dec);

endmodule

// File: rtl/apb_interconnect_n.sv
// ---------------------------------------------------------------------------
// apb_interconnect_n
// APB4 interconnect: one CPU master to NUM_SLAVES slaves via base/limit map,
// PSEL held through ACCESS, per-transfer PREADY timeout with abort, unmapped
// error response and sticky error address capture.
//   pclk, preset_n : clock, synchronous active-low reset
//   bus            : apb_interconnect_n_if.slave (CPU and peripheral buses)
//   err_unmapped   : 1-cycle pulse when an unmapped transfer completes
//   err_timeout    : 1-cycle pulse in the abort response cycle
//   err_addr       : address of the most recent errored transfer
// ---------------------------------------------------------------------------
module apb_interconnect_n
    import apb_interconnect_n_pkg::*;
#(
    parameter int                           NUM_SLAVES     = DEF_NUM_SLAVES,
    parameter int                           ADDR_W         = 32,
    parameter int                           DATA_W         = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE       = DEF_SLV_BASE,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_LIMIT      = DEF_SLV_LIMIT,
    parameter int                           TIMEOUT_CYCLES = 256
) (
    input  logic               pclk,
    input  logic               preset_n,
    apb_interconnect_n_if.slave bus,
    output logic               err_unmapped,
    output logic               err_timeout,
    output logic [ADDR_W-1:0]  err_addr
);

    // A zero timeout still needs a 1-bit counter to keep the logic legal.
    localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST =
        TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    apb_ic_state_e          state, state_nxt;
    logic [NUM_SLAVES-1:0]  dec, sel_q;
    logic                   unmapped, unmapped_q;
    logic [TMO_W-1:0]       tmo_cnt;
    logic                   setup, active, tmo_hit;
    logic                   sel_ready, sel_err;
    logic [DATA_W-1:0]      sel_rdata;
    logic [NUM_SLAVES-1:0]  psel_o, penable_o;
    logic                   m_pready_o, m_pslverr_o;
    logic [DATA_W-1:0]      m_prdata_o;

    apb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .SLV_BASE   (SLV_BASE),
        .SLV_LIMIT  (SLV_LIMIT)
    ) u_dec (
        .paddr    (bus.m_paddr),
        .psel     (bus.m_psel),
        .dec      (dec),
        .unmapped (unmapped)
    );

    assign setup  = bus.m_psel & ~bus.m_penable;
    assign active = bus.m_psel & bus.m_penable;

    // AND-OR response mux over the slave captured at SETUP.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                sel_rdata = sel_rdata | bus.s_prdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign sel_ready = |(bus.s_pready & sel_q);
    assign sel_err   = |(bus.s_pslverr & sel_q);
    assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

    // Next state plus every bus-facing output. The abort is decided in the
    // last waited ACCESS cycle, but the error response is only presented in
    // the following ABORT cycle so the master never sees a half response.
    always_comb begin
        state_nxt    = state;
        psel_o       = '0;
        penable_o    = '0;
        m_pready_o   = 1'b0;
        m_prdata_o   = '0;
        m_pslverr_o  = 1'b0;
        err_unmapped = 1'b0;
        err_timeout  = 1'b0;
        case (state)
            IDLE: begin
                if (setup) begin
                    psel_o    = dec;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                psel_o    = sel_q;
                penable_o = bus.m_penable ? sel_q : '0;
                if (!bus.m_psel) begin
                    state_nxt = IDLE;
                end else if (active) begin
                    if (unmapped_q) begin
                        m_pready_o   = 1'b1;
                        m_pslverr_o  = 1'b1;
                        err_unmapped = 1'b1;
                        state_nxt    = IDLE;
                    end else begin
                        m_pready_o  = sel_ready;
                        m_prdata_o  = sel_rdata;
                        m_pslverr_o = sel_err;
                        if (sel_ready) begin
                            state_nxt = IDLE;
                        end else if (tmo_hit) begin
                            state_nxt = ABORT;
                        end
                    end
                end
            end
            ABORT: begin
                m_pready_o  = 1'b1;
                m_pslverr_o = 1'b1;
                err_timeout = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, SETUP capture, saturating wait counter and sticky error address.
    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state      <= IDLE;
            sel_q      <= '0;
            unmapped_q <= 1'b0;
            tmo_cnt    <= '0;
            err_addr   <= '0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && setup) begin
                sel_q      <= dec;
                unmapped_q <= unmapped;
                tmo_cnt    <= '0;
            end else if ((state == ACCESS) && active && !unmapped_q &&
                         !sel_ready && (tmo_cnt != '1)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (err_unmapped || err_timeout) begin
                err_addr <= bus.m_paddr;
            end
        end
    end

    assign bus.s_paddr   = bus.m_paddr;
    assign bus.s_pwrite  = bus.m_pwrite;
    assign bus.s_pwdata  = bus.m_pwdata;
    assign bus.s_pstrb   = bus.m_pstrb;
    assign bus.s_psel    = psel_o;
    assign bus.s_penable = penable_o;
    assign bus.m_pready  = m_pready_o;
    assign bus.m_prdata  = m_prdata_o;
    assign bus.m_pslverr = m_pslverr_o;

    a_psel_onehot : assert property (@(posedge pclk) disable iff (!preset_n)
        $onehot0(psel_o));

    a_psel_held : assert property (@(posedge pclk) disable iff (!preset_n)
        (state == ACCESS) ##1 (state == ACCESS) |-> $stable(psel_o));

    a_pready_single : assert property (@(posedge pclk) disable iff (!preset_n)
        m_pready_o |=> !m_pready_o);

endmodule

// File: tb/tb_apb_interconnect_n.sv
// ---------------------------------------------------------------------------
// tb_apb_interconnect_n
// Self-checking bench for apb_interconnect_n: a directed vector table with
// hand-derived expectations, hand-written reset / PSEL-drop sequences and
// randomized transfers whose expectations come from a behavioural address
// map and wait/timeout rules kept here.
// ---------------------------------------------------------------------------
module tb_apb_interconnect_n;

    localparam int NS  = 5;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    typedef struct {
        logic [31:0] addr;
        bit          write;
        int          waits;
        bit          slvErr;
        logic [31:0] rdata;
        int          expSlave;
        bit          expTimeout;
    } vec_t;

    logic          pclk = 1'b0;
    logic          preset_n;
    logic          err_unmapped;
    logic          err_timeout;
    logic [AW-1:0] err_addr;

    int            checks   = 0;
    int            failures = 0;
    logic [AW-1:0] expErrAddr;

    int unsigned mapBase [NS] = '{32'h0000_0000, 32'h0000_8000, 32'h0002_8000,
                                  32'h0002_A000, 32'h0002_B000};
    int unsigned mapLimit[NS] = '{32'h0000_7FFF, 32'h0002_7FFF, 32'h0002_9FFF,
                                  32'h0002_AFFF, 32'h0002_BFFF};

    apb_interconnect_n_if #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_interconnect_n #(
        .NUM_SLAVES     (NS),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .pclk         (pclk),
        .preset_n     (preset_n),
        .bus          (bus),
        .err_unmapped (err_unmapped),
        .err_timeout  (err_timeout),
        .err_addr     (err_addr)
    );

    always #5 pclk = ~pclk;

    // Reference map: first window containing the address, -1 if none.
    function automatic int modelDecode(input logic [31:0] addr);
        for (int i = 0; i < NS; i++) begin
            if (addr >= mapBase[i] && addr <= mapLimit[i]) return i;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit psel, input bit penable,
                                 input logic [31:0] addr, input bit write);
        bus.m_psel    = psel;
        bus.m_penable = penable;
        bus.m_paddr   = addr;
        bus.m_pwrite  = write;
        bus.m_pwdata  = $urandom;
        bus.m_pstrb   = 4'($urandom);
    endtask

    // Every non-target slave gets random noise so a wrong mux leg shows up.
    task automatic setSlaves(input int tgt, input bit rdy, input bit err,
                             input logic [31:0] rdata);
        for (int i = 0; i < NS; i++) begin
            bus.s_prdata[i*DW +: DW] = $urandom;
            bus.s_pready[i]          = 1'($urandom_range(0, 1));
            bus.s_pslverr[i]         = 1'($urandom_range(0, 1));
        end
        if (tgt >= 0) begin
            bus.s_prdata[tgt*DW +: DW] = rdata;
            bus.s_pready[tgt]          = rdy;
            bus.s_pslverr[tgt]         = err;
        end
    endtask

    task automatic checkCycle(input string tag, input logic [NS-1:0] ePsel,
                              input logic [NS-1:0] ePen, input bit eRdy,
                              input bit eErr, input logic [31:0] eRdata,
                              input bit eUnm, input bit eTmo);
        @(negedge pclk);
        checkOutput({tag, " s_psel"},       64'(bus.s_psel),    64'(ePsel));
        checkOutput({tag, " s_penable"},    64'(bus.s_penable), 64'(ePen));
        checkOutput({tag, " m_pready"},     64'(bus.m_pready),  64'(eRdy));
        checkOutput({tag, " m_pslverr"},    64'(bus.m_pslverr), 64'(eErr));
        checkOutput({tag, " m_prdata"},     64'(bus.m_prdata),  64'(eRdata));
        checkOutput({tag, " err_unmapped"}, 64'(err_unmapped),  64'(eUnm));
        checkOutput({tag, " err_timeout"},  64'(err_timeout),   64'(eTmo));
    endtask

    task automatic nextCycle();
        @(posedge pclk);
        #1;
    endtask

    // One complete transfer starting with SETUP in the current cycle; returns
    // one cycle after the response so the next SETUP can follow directly.
    task automatic runXfer(input vec_t v, input string tag);
        logic [NS-1:0] oh;
        bit            unm;
        bit            last;
        oh  = '0;
        unm = (v.expSlave < 0);
        if (!unm) oh[v.expSlave] = 1'b1;

        applyStimulus(1'b1, 1'b0, v.addr, v.write);
        setSlaves(-1, 1'b0, 1'b0, 32'h0);
        checkCycle({tag, " setup"}, oh, '0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput({tag, " s_paddr"},  64'(bus.s_paddr),  64'(v.addr));
        checkOutput({tag, " s_pwrite"}, 64'(bus.s_pwrite), 64'(v.write));
        checkOutput({tag, " s_pwdata"}, 64'(bus.s_pwdata), 64'(bus.m_pwdata));
        checkOutput({tag, " s_pstrb"},  64'(bus.s_pstrb),  64'(bus.m_pstrb));
        checkOutput({tag, " err_addr"}, 64'(err_addr),     64'(expErrAddr));
        nextCycle();
        bus.m_penable = 1'b1;

        if (unm) begin
            setSlaves(-1, 1'b0, 1'b0, 32'h0);
            checkCycle({tag, " unmapped"}, '0, '0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0);
            expErrAddr = v.addr;
        end else if (v.expTimeout) begin
            for (int k = 0; k < TMO; k++) begin
                setSlaves(v.expSlave, 1'b0, 1'b0, v.rdata);
                checkCycle($sformatf("%s wait%0d", tag, k), oh, oh, 1'b0, 1'b0,
                           v.rdata, 1'b0, 1'b0);
                nextCycle();
            end
            setSlaves(-1, 1'b0, 1'b0, 32'h0);
            checkCycle({tag, " abort"}, '0, '0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1);
            expErrAddr = v.addr;
        end else begin
            for (int k = 0; k <= v.waits; k++) begin
                last = (k == v.waits);
                setSlaves(v.expSlave, last, last & v.slvErr, v.rdata);
                checkCycle($sformatf("%s access%0d", tag, k), oh, oh, last,
                           last & v.slvErr, v.rdata, 1'b0, 1'b0);
                if (!last) nextCycle();
            end
        end
        nextCycle();
    endtask

    initial begin
        vec_t dirVec[14];
        vec_t rv;
        int   mode;

        // addr, write, waits, slvErr, rdata, expSlave, expTimeout
        dirVec[0]  = '{32'h0002_A004, 1'b1, 0,  1'b0, 32'h0BAD_F00D,  3, 1'b0};
        dirVec[1]  = '{32'h0002_8010, 1'b0, 3,  1'b0, 32'hDEAD_BEEF,  2, 1'b0};
        dirVec[2]  = '{32'h0003_0000, 1'b0, 0,  1'b0, 32'h1111_1111, -1, 1'b0};
        dirVec[3]  = '{32'h0000_8000, 1'b0, 10, 1'b0, 32'h1234_5678,  1, 1'b1};
        dirVec[4]  = '{32'h0000_0000, 1'b0, 0,  1'b0, 32'h0000_1111,  0, 1'b0};
        dirVec[5]  = '{32'h0002_B000, 1'b1, 0,  1'b0, 32'h0000_2222,  4, 1'b0};
        dirVec[6]  = '{32'h0000_7FFF, 1'b0, 1,  1'b0, 32'hA0A0_7FFF,  0, 1'b0};
        dirVec[7]  = '{32'h0002_7FFF, 1'b0, 3,  1'b0, 32'hB1B1_7FFF,  1, 1'b0};
        dirVec[8]  = '{32'h0002_9FFF, 1'b1, 2,  1'b1, 32'hC2C2_9FFF,  2, 1'b0};
        dirVec[9]  = '{32'h0002_AFFF, 1'b0, 0,  1'b0, 32'hD3D3_AFFF,  3, 1'b0};
        dirVec[10] = '{32'h0002_BFFF, 1'b0, 0,  1'b1, 32'hE4E4_BFFF,  4, 1'b0};
        dirVec[11] = '{32'h0002_C000, 1'b1, 0,  1'b0, 32'h5555_AAAA, -1, 1'b0};
        dirVec[12] = '{32'hFFFF_FFFF, 1'b0, 0,  1'b0, 32'h6666_9999, -1, 1'b0};
        dirVec[13] = '{32'h0002_8000, 1'b0, 4,  1'b0, 32'h7777_8888,  2, 1'b1};

        preset_n   = 1'b0;
        expErrAddr = '0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        setSlaves(-1, 1'b0, 1'b0, 32'h0);
        repeat (3) @(posedge pclk);
        #1;
        checkCycle("reset", '0, '0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("reset err_addr", 64'(err_addr), 64'h0);
        nextCycle();
        preset_n = 1'b1;

        // PENABLE without a SETUP must not select anything.
        applyStimulus(1'b1, 1'b1, 32'h0002_A000, 1'b0);
        checkCycle("idle_penable0", '0, '0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        nextCycle();
        checkCycle("idle_penable1", '0, '0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        nextCycle();

        $display("[TB] directed vectors");
        for (int i = 0; i < 14; i++) begin
            runXfer(dirVec[i], $sformatf("dir%0d", i));
        end

        // Master abandons a waited transfer: no response, back to IDLE.
        $display("[TB] psel drop sequence");
        applyStimulus(1'b1, 1'b0, 32'h0000_0010, 1'b0);
        setSlaves(-1, 1'b0, 1'b0, 32'h0);
        checkCycle("drop setup", 5'b00001, '0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        nextCycle();
        bus.m_penable = 1'b1;
        setSlaves(0, 1'b0, 1'b0, 32'hCAFE_0010);
        checkCycle("drop wait0", 5'b00001, 5'b00001, 1'b0, 1'b0, 32'hCAFE_0010,
                   1'b0, 1'b0);
        nextCycle();
        bus.m_psel    = 1'b0;
        bus.m_penable = 1'b0;
        setSlaves(0, 1'b1, 1'b0, 32'hCAFE_0011);
        @(negedge pclk);
        checkOutput("drop released m_pready", 64'(bus.m_pready), 64'h0);
        checkOutput("drop released s_penable", 64'(bus.s_penable), 64'h0);
        nextCycle();
        checkCycle("drop idle", '0, '0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        nextCycle();

        // Reset in the middle of a waited transfer.
        $display("[TB] reset mid-transfer sequence");
        applyStimulus(1'b1, 1'b0, 32'h0000_8000, 1'b0);
        setSlaves(-1, 1'b0, 1'b0, 32'h0);
        checkCycle("rst setup", 5'b00010, '0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        nextCycle();
        bus.m_penable = 1'b1;
        setSlaves(1, 1'b0, 1'b0, 32'h1111_2222);
        checkCycle("rst wait0", 5'b00010, 5'b00010, 1'b0, 1'b0, 32'h1111_2222,
                   1'b0, 1'b0);
        nextCycle();
        preset_n = 1'b0;
        setSlaves(1, 1'b0, 1'b0, 32'h1111_2222);
        nextCycle();
        expErrAddr = '0;
        checkCycle("rst dropped", '0, '0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("rst err_addr", 64'(err_addr), 64'h0);
        nextCycle();
        preset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkCycle("rst idle", '0, '0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        nextCycle();
        rv = '{32'h0000_0004, 1'b1, 1, 1'b0, 32'hA5A5_0004, 0, 1'b0};
        runXfer(rv, "post_rst");

        $display("[TB] randomized transfers");
        for (int n = 0; n < 40; n++) begin
            mode = int'($urandom_range(0, 5));
            if (mode < NS) begin
                rv.addr = mapBase[mode] + ($urandom % (mapLimit[mode] - mapBase[mode] + 1));
            end else begin
                rv.addr = $urandom;
            end
            rv.write      = 1'($urandom_range(0, 1));
            rv.waits      = int'($urandom_range(0, 6));
            rv.slvErr     = ($urandom_range(0, 3) == 0);
            rv.rdata      = $urandom;
            rv.expSlave   = modelDecode(rv.addr);
            rv.expTimeout = (rv.expSlave >= 0) && (rv.waits >= TMO);
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
                setSlaves(-1, 1'b0, 1'b0, 32'h0);
                checkCycle($sformatf("rnd%0d idle", n), '0, '0, 1'b0, 1'b0,
                           32'h0, 1'b0, 1'b0);
                nextCycle();
            end
            runXfer(rv, $sformatf("rnd%0d", n));
        end

        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge pclk);
        checkOutput("final err_addr", 64'(err_addr), 64'(expErrAddr));
        checkOutput("final s_psel", 64'(bus.s_psel), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
